// File: rtl/gmem_pkg.sv
// gmem_pkg: shared types and constants for the graphics-memory arbiter.
//   gmem_addr_t / gmem_dat_t : default-width address and pixel word types
//   GMEM_DEPTH               : number of valid words (320x240)
//   STARVE_MAX_DEFAULT       : default CPU starvation bound
//   owner_e                  : which requester issued an access
//   rsp_tag_t                : per-access tag carried alongside the read latency
//   arb_state_e              : arbitration FSM states
package gmem_pkg;

    localparam int GMEM_ADDR_W        = 17;
    localparam int GMEM_DATA_W        = 8;
    localparam int GMEM_DEPTH         = 76800;
    localparam int STARVE_MAX_DEFAULT = 4;

    typedef logic [GMEM_ADDR_W-1:0] gmem_addr_t;
    typedef logic [GMEM_DATA_W-1:0] gmem_dat_t;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_CPU  = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   is_read;
        logic   in_range;
    } rsp_tag_t;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/gmem_rsp_pipe.sv
// gmem_rsp_pipe: two-stage tag pipeline that steers gmem read data back to
// the requester that issued the read.
//   clk, rst          : clock, synchronous active-low reset
//   push, tag_in      : a grant happened this cycle, with its tag
//   mem_rdata         : gmem read data (valid one cycle after mem_en)
//   disp_rvalid/rdata : display read response
//   cpu_rvalid/rdata  : CPU read response
// Stage 1 lines up with mem_en, stage 2 with mem_rdata. The rvalid flags are
// registers; rdata presents the live (or zeroed) memory word in the rvalid
// cycle and a held copy of it afterwards.
module gmem_rsp_pipe
    import gmem_pkg::*;
#(
    parameter int DATA_W = GMEM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  rsp_tag_t          tag_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata
);

    logic              s1_vld_r;
    rsp_tag_t          s1_tag_r;
    logic              disp_vld_r;
    logic              cpu_vld_r;
    logic              s2_in_range_r;
    logic [DATA_W-1:0] disp_hold_r;
    logic [DATA_W-1:0] cpu_hold_r;
    logic [DATA_W-1:0] rsp_data_s;

    // Tag pipeline: only reads occupy a slot; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld_r      <= 1'b0;
            s1_tag_r      <= '{owner: OWN_DISP, is_read: 1'b0, in_range: 1'b0};
            disp_vld_r    <= 1'b0;
            cpu_vld_r     <= 1'b0;
            s2_in_range_r <= 1'b0;
        end else begin
            s1_vld_r      <= push & tag_in.is_read;
            s1_tag_r      <= tag_in;
            disp_vld_r    <= s1_vld_r & (s1_tag_r.owner == OWN_DISP);
            cpu_vld_r     <= s1_vld_r & (s1_tag_r.owner == OWN_CPU);
            s2_in_range_r <= s1_tag_r.in_range;
        end
    end

    // Response data: out-of-range reads never touched memory, so return zero.
    always_comb begin
        rsp_data_s = {DATA_W{1'b0}};
        if (s2_in_range_r) begin
            rsp_data_s = mem_rdata;
        end else begin
            rsp_data_s = {DATA_W{1'b0}};
        end
    end

    // Hold registers keep the last delivered word while rvalid is low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_hold_r <= {DATA_W{1'b0}};
            cpu_hold_r  <= {DATA_W{1'b0}};
        end else begin
            if (disp_vld_r) begin
                disp_hold_r <= rsp_data_s;
            end
            if (cpu_vld_r) begin
                cpu_hold_r <= rsp_data_s;
            end
        end
    end

    // Output steering: live word in the rvalid cycle, held copy otherwise.
    always_comb begin
        disp_rvalid = disp_vld_r;
        cpu_rvalid  = cpu_vld_r;
        disp_rdata  = disp_hold_r;
        cpu_rdata   = cpu_hold_r;
        if (disp_vld_r) begin
            disp_rdata = rsp_data_s;
        end else begin
            disp_rdata = disp_hold_r;
        end
        if (cpu_vld_r) begin
            cpu_rdata = rsp_data_s;
        end else begin
            cpu_rdata = cpu_hold_r;
        end
    end

endmodule

// File: rtl/gmem_arbiter.sv
// gmem_arbiter: shares the single-port gmem between display scanout reads
// (priority) and CPU reads/writes, with a starvation bound for the CPU.
//   clk, rst                  : clock, synchronous active-low reset
//   disp_req/addr/gnt         : display read request and same-cycle grant
//   disp_rvalid/rdata         : display read response, 2 cycles after grant
//   cpu_req/we/addr/wdata/gnt : CPU access request and same-cycle grant
//   cpu_rvalid/rdata          : CPU read response, 2 cycles after grant
//   cpu_err                   : pulse one cycle after an out-of-range CPU grant
//   mem_en/we/addr/wdata      : registered gmem port
//   mem_rdata                 : gmem read data
module gmem_arbiter
    import gmem_pkg::*;
#(
    parameter int ADDR_W     = GMEM_ADDR_W,
    parameter int DATA_W     = GMEM_DATA_W,
    parameter int DEPTH      = GMEM_DEPTH,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [3:0]        STARVE_L = 4'(STARVE_MAX);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [3:0]        starve_cnt_r;
    logic              disp_gnt_s;
    logic              cpu_gnt_s;
    logic              disp_in_range_s;
    logic              cpu_in_range_s;
    rsp_tag_t          tag_s;
    logic              mem_en_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              cpu_err_r;

    assign disp_in_range_s = (disp_addr < DEPTH_A);
    assign cpu_in_range_s  = (cpu_addr < DEPTH_A);

    // Arbitration: a starved CPU jumps the queue once, then FORCED hands the
    // next slot back to the display so forcing cannot repeat back-to-back.
    always_comb begin
        disp_gnt_s  = 1'b0;
        cpu_gnt_s   = 1'b0;
        state_nxt_s = state_r;
        case (state_r)
            ARB_NORMAL: begin
                if (cpu_req && (starve_cnt_r == STARVE_L)) begin
                    cpu_gnt_s   = 1'b1;
                    state_nxt_s = ARB_FORCED;
                end else if (disp_req) begin
                    disp_gnt_s = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt_s = 1'b1;
                end else begin
                    state_nxt_s = ARB_NORMAL;
                end
            end
            ARB_FORCED: begin
                if (disp_req) begin
                    disp_gnt_s = 1'b1;
                end else if (cpu_req) begin
                    cpu_gnt_s = 1'b1;
                end else begin
                    disp_gnt_s = 1'b0;
                end
                state_nxt_s = ARB_NORMAL;
            end
            default: begin
                state_nxt_s = ARB_NORMAL;
            end
        endcase
    end

    assign disp_gnt = disp_gnt_s;
    assign cpu_gnt  = cpu_gnt_s;

    // FSM state register and starvation counter (saturating).
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ARB_NORMAL;
            starve_cnt_r <= 4'd0;
        end else begin
            state_r <= state_nxt_s;
            if (!cpu_req || cpu_gnt_s) begin
                starve_cnt_r <= 4'd0;
            end else if (starve_cnt_r < STARVE_L) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
            end
        end
    end

    // gmem port registers: launched from the winner; addr/wdata hold when idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            cpu_err_r   <= 1'b0;
        end else begin
            cpu_err_r <= cpu_gnt_s & ~cpu_in_range_s;
            if (disp_gnt_s) begin
                mem_en_r    <= disp_in_range_s;
                mem_we_r    <= 1'b0;
                mem_addr_r  <= disp_addr;
                mem_wdata_r <= {DATA_W{1'b0}};
            end else if (cpu_gnt_s) begin
                mem_en_r    <= cpu_in_range_s;
                mem_we_r    <= cpu_we & cpu_in_range_s;
                mem_addr_r  <= cpu_addr;
                mem_wdata_r <= cpu_we ? cpu_wdata : {DATA_W{1'b0}};
            end else begin
                mem_en_r <= 1'b0;
                mem_we_r <= 1'b0;
            end
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign cpu_err   = cpu_err_r;

    // Tag for the response pipeline, built from whichever requester won.
    always_comb begin
        tag_s = '{owner: OWN_DISP, is_read: 1'b0, in_range: 1'b0};
        if (cpu_gnt_s) begin
            tag_s = '{owner: OWN_CPU, is_read: ~cpu_we, in_range: cpu_in_range_s};
        end else begin
            tag_s = '{owner: OWN_DISP, is_read: disp_gnt_s, in_range: disp_in_range_s};
        end
    end

    gmem_rsp_pipe #(
        .DATA_W (DATA_W)
    ) u_rsp_pipe (
        .clk         (clk),
        .rst         (rst),
        .push        (disp_gnt_s | cpu_gnt_s),
        .tag_in      (tag_s),
        .mem_rdata   (mem_rdata),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata)
    );

endmodule

// File: tb/tb_gmem_arbiter.sv
// Directed bench for gmem_arbiter with a small behavioural gmem model.
// Memory preload: word i holds (i[7:0] ^ 8'h5A), so address 100 reads 8'h3E.
module tb_gmem_arbiter;

    logic        clk;
    logic        rst;
    logic        disp_req;
    logic [16:0] disp_addr;
    logic        disp_gnt;
    logic        disp_rvalid;
    logic [7:0]  disp_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        cpu_err;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  tb_mem [0:255];
    int          checks;
    int          failures;

    gmem_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_gnt    (disp_gnt),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .cpu_err     (cpu_err),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural synchronous single-port RAM (low 8 address bits only).
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                tb_mem[mem_addr[7:0]] <= mem_wdata;
            end else begin
                mem_rdata <= tb_mem[mem_addr[7:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = 8'(i) ^ 8'h5A;
        end
        rst       = 1'b0;
        disp_req  = 1'b0;
        disp_addr = 17'd0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 17'd0;
        cpu_wdata = 8'h00;
        step();
        step();
        rst = 1'b1;
        step();

        // Reset state
        chk("rst_outputs", {disp_gnt, disp_rvalid, cpu_gnt, cpu_rvalid, cpu_err, mem_en, mem_we}, 32'd0);
        chk("rst_data", {mem_addr, mem_wdata, disp_rdata}, 32'd0);
        chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        chk("rst_starve", {28'd0, dut.starve_cnt_r}, 32'd0);

        // Display read of address 100
        disp_req  = 1'b1;
        disp_addr = 17'd100;
        #1;
        chk("disp_gnt", {disp_gnt, cpu_gnt}, 32'd2);
        step();
        disp_req = 1'b0;
        chk("disp_mem_issue", {mem_en, mem_we, mem_addr}, {14'd0, 1'b1, 1'b0, 17'd100});
        chk("disp_no_early_rvalid", {31'd0, disp_rvalid}, 32'd0);
        step();
        chk("disp_rvalid", {disp_rvalid, disp_rdata}, {23'd0, 1'b1, 8'h3E});
        chk("disp_idle_mem_en", {31'd0, mem_en}, 32'd0);
        step();
        chk("disp_rdata_hold", {disp_rvalid, disp_rdata}, {23'd0, 1'b0, 8'h3E});

        // CPU write addr 5 = A3, then read it back
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 17'd5;
        cpu_wdata = 8'hA3;
        #1;
        chk("cpu_wr_gnt", {disp_gnt, cpu_gnt}, 32'd1);
        step();
        cpu_req = 1'b0;
        chk("cpu_wr_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {5'd0, 1'b1, 1'b1, 17'd5, 8'hA3});
        step();
        chk("cpu_wr_no_rvalid", {30'd0, cpu_rvalid, cpu_err}, 32'd0);
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        #1;
        chk("cpu_rd_gnt", {disp_gnt, cpu_gnt}, 32'd1);
        step();
        cpu_req = 1'b0;
        chk("cpu_rd_mem", {mem_en, mem_we, mem_wdata}, {22'd0, 1'b1, 1'b0, 8'h00});
        chk("cpu_rd_no_early", {31'd0, cpu_rvalid}, 32'd0);
        step();
        chk("cpu_rd_data", {cpu_rvalid, cpu_rdata}, {23'd0, 1'b1, 8'hA3});
        step();

        // Sustained display + CPU: CPU wins every 5th cycle
        disp_req  = 1'b1;
        disp_addr = 17'd7;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 17'd9;
        #1;
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("starve_pat_%0d", i), {30'd0, disp_gnt, cpu_gnt},
                ((i % 5) == 4) ? 32'd1 : 32'd2);
            step();
        end
        disp_req = 1'b0;
        cpu_req  = 1'b0;
        step();
        step();
        step();

        // Simultaneous requests with an empty starvation count
        disp_req  = 1'b1;
        disp_addr = 17'd20;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 17'd6;
        cpu_wdata = 8'h11;
        #1;
        chk("simul_disp_wins", {disp_gnt, cpu_gnt}, 32'd2);
        step();
        disp_req = 1'b0;
        #1;
        chk("simul_cpu_next", {disp_gnt, cpu_gnt}, 32'd1);
        step();
        cpu_req = 1'b0;
        chk("simul_cpu_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {5'd0, 1'b1, 1'b1, 17'd6, 8'h11});
        step();
        step();

        // CPU read out of range
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 17'd76800;
        #1;
        chk("oor_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
        step();
        cpu_req = 1'b0;
        chk("oor_cpu_k1", {mem_en, mem_we, cpu_err, cpu_rvalid}, 32'b0010);
        step();
        chk("oor_cpu_k2", {cpu_err, cpu_rvalid, cpu_rdata}, {22'd0, 1'b0, 1'b1, 8'h00});
        step();

        // Display read out of range
        disp_req  = 1'b1;
        disp_addr = 17'd80000;
        #1;
        chk("oor_disp_gnt", {31'd0, disp_gnt}, 32'd1);
        step();
        disp_req = 1'b0;
        chk("oor_disp_k1", {mem_en, cpu_err}, 32'd0);
        step();
        chk("oor_disp_k2", {disp_rvalid, disp_rdata}, {23'd0, 1'b1, 8'h00});
        step();

        // Reset while a display read is in flight
        disp_req  = 1'b1;
        disp_addr = 17'd100;
        #1;
        chk("mid_rst_gnt", {31'd0, disp_gnt}, 32'd1);
        rst = 1'b0;
        step();
        disp_req = 1'b0;
        chk("mid_rst_k1", {mem_en, mem_we, mem_addr}, 32'd0);
        step();
        rst = 1'b1;
        chk("mid_rst_k2", {disp_rvalid, cpu_rvalid, disp_rdata}, 32'd0);
        step();
        chk("mid_rst_k3", {disp_rvalid, cpu_rvalid, cpu_err, mem_en, mem_wdata}, 32'd0);
        chk("mid_rst_starve", {28'd0, dut.starve_cnt_r}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gmem_arbiter.md
Name: gmem_arbiter

Overview:
Shares the single-port graphics memory (gmem) between two requesters: the display scanout read path and the CPU bus-side read/write path. Display reads have priority. A starvation counter guarantees the CPU one slot after a bounded wait. Sits between the VGA controller, the UIBI bus slave glue and the gmem RAM; the gmem port is driven from registers.

Parameters:
ADDR_W, 17, gmem word address width
DATA_W, 8, pixel word width (one 256-colour pixel per word)
DEPTH, 76800, valid words (320x240); addresses >= DEPTH are out of range
STARVE_MAX, 4, max consecutive cycles the CPU may wait with cpu_req high before a forced CPU grant (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
disp_req  in  1  display read request
disp_addr  in  ADDR_W  display read address
disp_gnt  out  1  display request accepted this cycle
disp_rvalid  out  1  display read data valid
disp_rdata  out  DATA_W  display read data
cpu_req  in  1  CPU access request
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU request accepted this cycle
cpu_rvalid  out  1  CPU read data valid (reads only)
cpu_rdata  out  DATA_W  CPU read data
cpu_err  out  1  one-cycle pulse: the granted CPU access was out of range
mem_en  out  1  gmem port enable (registered)
mem_we  out  1  gmem write enable (registered)
mem_addr  out  ADDR_W  gmem address (registered)
mem_wdata  out  DATA_W  gmem write data (registered)
mem_rdata  in  DATA_W  gmem read data, valid one cycle after mem_en with mem_we=0

Behaviour:
- All state changes on posedge clk. rst=0 sampled at an edge clears all registers. Every output is 0 after reset, and the starvation counter is 0.
- Grant logic is combinational from the current-cycle requests and registered state.
- At most one grant per cycle.
- Requesters must hold req, addr, we and wdata stable until they see their gnt.
- Arbitration FSM has two states:
  - NORMAL: if cpu_req and starve_cnt == STARVE_MAX, grant CPU and go to FORCED. Otherwise disp_req wins, then cpu_req.
  - FORCED: one cycle only. Grant display if disp_req, else CPU if cpu_req. Always return to NORMAL.
- FORCED prevents back-to-back CPU forcing.
- starve_cnt (4 bits):
  - Cleared when cpu_gnt is high or cpu_req is low.
  - Otherwise increments, saturating at STARVE_MAX.
- Edge after a grant (cycle k -> k+1):
  - mem_en=1, mem_addr and mem_we are captured from the winner.
  - mem_wdata is captured from cpu_wdata on CPU writes and is 0 otherwise.
  - mem_en=0 on cycles with no grant; mem_addr and mem_wdata hold their last value.
- Out-of-range CPU access (cpu_addr >= DEPTH):
  - Granted normally, but mem_en=0 and mem_we=0 are issued.
  - cpu_err pulses at k+1.
  - A read still produces cpu_rvalid at k+2 with cpu_rdata=0.
- Out-of-range display address: mem access suppressed, disp_rvalid at k+2 with data 0. No error output.
- Read latency is fixed at 2 cycles from grant to rvalid.
- A 2-deep tag pipeline (owner, is_read, in_range) steers mem_rdata to the correct requester.
- rdata outputs are registered and hold their value when rvalid=0.
- CPU writes produce no rvalid.
- Throughput is one access per cycle. Display plus CPU sustained requests give the CPU >= 1 slot per STARVE_MAX+1 cycles.
- Simultaneous requests with starve_cnt < STARVE_MAX: display wins, CPU waits.
- Reset mid-operation: in-flight tags are discarded, so no rvalid appears after reset even if a read was pending.

Decomposition:
- Package gmem_pkg:
  - Typedefs gmem_addr_t and gmem_dat_t.
  - Constants GMEM_DEPTH and STARVE_MAX_DEFAULT.
  - Owner enum {OWN_DISP, OWN_CPU}.
  - Struct rsp_tag_t {owner, is_read, in_range}.
- One sub-module, gmem_rsp_pipe: the 2-stage tag pipeline plus the rdata demux and registers. The arbiter FSM and starvation counter stay in the top.

Test Plan:
- Reset then idle: all outputs 0. disp_req=1, addr=100 at cycle 0 -> disp_gnt=1 at 0, mem_en=1/mem_addr=100 at 1, disp_rvalid=1 with mem_rdata value at 2.
- CPU write addr=5, data=0xA3, no display traffic -> cpu_gnt at 0, mem_we=1/mem_wdata=0xA3 at 1, no cpu_rvalid. A following CPU read of addr 5 returns 0xA3 2 cycles after its grant.
- disp_req held high, cpu_req held high, STARVE_MAX=4 -> display granted cycles 0-3, CPU granted cycle 4, display cycle 5; pattern repeats every 5 cycles.
- cpu_req at the same cycle as disp_req with starve_cnt=0 -> disp_gnt=1, cpu_gnt=0. CPU granted the next cycle once disp_req drops.
- CPU read addr=76800 -> cpu_gnt, mem_en=0, cpu_err pulse at +1, cpu_rvalid with rdata=0 at +2.
- Display read granted, rst=0 on the next edge -> no disp_rvalid thereafter, all outputs 0, starve_cnt 0.
